// File: rtl/sar_adc_pkg.sv
// sar_adc_pkg: shared types and constants for the SAR ADC controller.
//   state_t       - controller FSM states
//   DEF_*         - default parameter values for sar_adc_ctrl
//   conv_latency  - cycles from the Start-sampling edge to the Done cycle
package sar_adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_SETTLE,
        ST_DECIDE,
        ST_DONE
    } state_t;

    localparam int DEF_N             = 8;
    localparam int DEF_SAMPLE_CYCLES = 4;
    localparam int DEF_SETTLE_CYCLES = 2;
    localparam bit DEF_COMP_POL      = 1'b1;

    // One cycle to enter SAMPLE, the track phase, then per bit a settle
    // window plus one decision cycle.
    function automatic int conv_latency(input int n, input int sample_cycles,
                                        input int settle_cycles);
        return 1 + sample_cycles + n * (settle_cycles + 1);
    endfunction

endpackage

// File: rtl/sar_phase_timer.sv
// sar_phase_timer: loadable down-counter timing the SAMPLE and SETTLE phases.
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset, clears the count
//   load     - load load_val (takes priority over dec)
//   load_val - value loaded; a phase of L cycles is loaded with L-1
//   dec      - decrement by one, saturating at zero
//   tc       - terminal count, high while the count is zero
module sar_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: successive-approximation ADC controller.
//   Clk      - rising-edge clock
//   Rst      - synchronous active-high reset, aborts any conversion
//   Start    - conversion request, sampled only in IDLE
//   Comp_In  - comparator decision, sampled on the edge ending DECIDE
//   Comp_En  - comparator evaluate strobe (DECIDE)
//   Sample   - track/hold control (SAMPLE)
//   Dac_Code - trial code to the DAC (SETTLE/DECIDE, else 0)
//   Busy     - high outside IDLE
//   Done     - one-cycle completion pulse
//   Data_Out - last completed result, updated on entry to DONE
// All outputs are registered from the next-state values so they line up
// with the state they belong to.
module sar_adc_ctrl
    import sar_adc_pkg::*;
#(
    parameter int N             = DEF_N,
    parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter bit COMP_POL      = DEF_COMP_POL
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Start,
    input  logic         Comp_In,
    output logic         Comp_En,
    output logic         Sample,
    output logic [N-1:0] Dac_Code,
    output logic         Busy,
    output logic         Done,
    output logic [N-1:0] Data_Out
);

    localparam int           PTR_W     = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0] ONE       = N'(1);
    localparam logic [7:0]   SAMPLE_LD = 8'(SAMPLE_CYCLES - 1);
    localparam logic [7:0]   SETTLE_LD = 8'(SETTLE_CYCLES - 1);

    state_t             state, state_nx;
    logic [N-1:0]       trial, trial_nx, trial_dec, data_nx;
    logic [PTR_W-1:0]   ptr, ptr_nx;
    logic               tmr_load, tmr_dec, tmr_tc;
    logic [7:0]         tmr_val;

    sar_phase_timer #(.W(8)) u_timer (
        .clk      (Clk),
        .rst      (Rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .tc       (tmr_tc)
    );

    always_comb begin
        state_nx  = state;
        trial_nx  = trial;
        ptr_nx    = ptr;
        data_nx   = Data_Out;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_dec   = 1'b0;
        // Trial with the bit under test resolved by the comparator.
        trial_dec = trial;
        if (Comp_In != COMP_POL) begin
            trial_dec = trial & ~(ONE << ptr);
        end

        case (state)
            ST_IDLE: begin
                trial_nx = '0;
                if (Start) begin
                    state_nx = ST_SAMPLE;
                    tmr_load = 1'b1;
                    tmr_val  = SAMPLE_LD;
                end
            end
            ST_SAMPLE: begin
                if (tmr_tc) begin
                    state_nx = ST_SETTLE;
                    trial_nx = ONE << (N - 1);
                    ptr_nx   = PTR_W'(N - 1);
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (tmr_tc) begin
                    state_nx = ST_DECIDE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_DECIDE: begin
                if (ptr != '0) begin
                    state_nx = ST_SETTLE;
                    ptr_nx   = ptr - 1'b1;
                    trial_nx = trial_dec | (ONE << (ptr - 1'b1));
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LD;
                end else begin
                    state_nx = ST_DONE;
                    trial_nx = trial_dec;
                    data_nx  = trial_dec;
                end
            end
            ST_DONE: begin
                // Start is ignored here; a held Start is picked up in IDLE.
                state_nx = ST_IDLE;
                trial_nx = '0;
            end
            default: begin
                state_nx = ST_IDLE;
                trial_nx = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= ST_IDLE;
            trial    <= '0;
            ptr      <= '0;
            Sample   <= 1'b0;
            Comp_En  <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Dac_Code <= '0;
            Data_Out <= '0;
        end else begin
            state    <= state_nx;
            trial    <= trial_nx;
            ptr      <= ptr_nx;
            Sample   <= (state_nx == ST_SAMPLE);
            Comp_En  <= (state_nx == ST_DECIDE);
            Busy     <= (state_nx != ST_IDLE);
            Done     <= (state_nx == ST_DONE);
            Dac_Code <= ((state_nx == ST_SETTLE) || (state_nx == ST_DECIDE)) ? trial_nx : '0;
            Data_Out <= data_nx;
        end
    end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb_sar_adc_ctrl: self-checking bench for sar_adc_ctrl. Two instances share
// clock and reset: [0] with a true comparator (COMP_POL=1), [1] with an
// inverted comparator (COMP_POL=0). Expected codes and DAC trial sequences
// come from an ideal binary-search model of the analog input code.
module tb_sar_adc_ctrl;

    localparam int N   = 8;
    localparam int SC  = 4;
    localparam int TC  = 2;
    localparam int LAT = 1 + SC + N * (TC + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic [1:0]        start = '0;
    logic [1:0]        comp_in, comp_en, sample, busy, done;
    logic [1:0][N-1:0] dac, dout;
    logic [1:0][N-1:0] vin = '0;
    logic              noise = 1'b0;

    int errs = 0;
    int checks = 0;

    sar_adc_ctrl #(.N(N), .SAMPLE_CYCLES(SC), .SETTLE_CYCLES(TC), .COMP_POL(1'b1)) dut (
        .Clk(clk), .Rst(rst), .Start(start[0]), .Comp_In(comp_in[0]),
        .Comp_En(comp_en[0]), .Sample(sample[0]), .Dac_Code(dac[0]),
        .Busy(busy[0]), .Done(done[0]), .Data_Out(dout[0])
    );

    sar_adc_ctrl #(.N(N), .SAMPLE_CYCLES(SC), .SETTLE_CYCLES(TC), .COMP_POL(1'b0)) dut_inv (
        .Clk(clk), .Rst(rst), .Start(start[1]), .Comp_In(comp_in[1]),
        .Comp_En(comp_en[1]), .Sample(sample[1]), .Dac_Code(dac[1]),
        .Busy(busy[1]), .Done(done[1]), .Data_Out(dout[1])
    );

    // Comparator models; outside the evaluate strobe the line carries noise
    // that the controller must not act on.
    always @(negedge clk) noise = 1'($urandom_range(0, 1));
    assign comp_in[0] = comp_en[0] ? (vin[0] >= dac[0]) : noise;
    assign comp_in[1] = comp_en[1] ? ~(vin[1] >= dac[1]) : noise;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Ideal SAR: binary search for the input code, recording each trial.
    logic [N-1:0] exp_tr[$];
    function automatic logic [N-1:0] sar_ref(input logic [N-1:0] v);
        logic [N-1:0] code;
        code = '0;
        exp_tr.delete();
        for (int b = N - 1; b >= 0; b--) begin
            logic [N-1:0] t;
            t = code | (N'(1) << b);
            exp_tr.push_back(t);
            if (v >= t) code = t;
        end
        return code;
    endfunction

    // One conversion on instance s. repulse: cycle at which Start is pulsed
    // again (0 = never). rst_at: cycle at which reset is applied (0 = never),
    // prev: Data_Out expected to survive that reset.
    task automatic conv(input int s, input logic [N-1:0] v, input int repulse,
                        input int rst_at, input logic [N-1:0] prev);
        logic [N-1:0] exp_code;
        logic [N-1:0] got_tr[$];
        int  done_k = 0;
        int  n_done = 0;
        bit  busy_ok = 1'b1;
        bit  dac_ok = 1'b1;
        exp_code = sar_ref(v);
        @(negedge clk);
        vin[s]   = v;
        start[s] = 1'b1;
        @(negedge clk);
        start[s] = 1'b0;
        for (int k = 1; k <= LAT + 3; k++) begin
            if (k > 1) @(negedge clk);
            if (comp_en[s]) got_tr.push_back(dac[s]);
            if (done[s]) begin
                n_done++;
                if (done_k == 0) done_k = k;
            end
            if (k <= LAT && !busy[s]) busy_ok = 1'b0;
            if ((sample[s] || done[s]) && dac[s] != '0) dac_ok = 1'b0;
            if (k == LAT + 1) begin
                chk("idle_busy", 32'(busy[s]), 32'd0);
                chk("idle_dac", 32'(dac[s]), 32'd0);
            end
            start[s] = (k == repulse);
            if (k == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_busy", 32'(busy[s]), 32'd0);
                chk("rst_done", 32'(done[s]), 32'd0);
                chk("rst_sample", 32'(sample[s]), 32'd0);
                chk("rst_comp_en", 32'(comp_en[s]), 32'd0);
                chk("rst_dac", 32'(dac[s]), 32'd0);
                chk("rst_dout", 32'(dout[s]), 32'(prev));
                for (int j = 0; j < LAT + 5; j++) begin
                    @(negedge clk);
                    if (done[s]) n_done++;
                end
                chk("rst_no_done", n_done, 0);
                chk("rst_dout_kept", 32'(dout[s]), 32'(prev));
                return;
            end
        end
        chk("done_cycle", done_k, LAT);
        chk("done_count", n_done, 1);
        chk("busy_held", 32'(busy_ok), 32'd1);
        chk("dac_zero", 32'(dac_ok), 32'd1);
        chk("data_out", 32'(dout[s]), 32'(exp_code));
        chk("trial_count", got_tr.size(), N);
        for (int i = 0; i < N && i < got_tr.size(); i++)
            chk($sformatf("trial%0d", i), 32'(got_tr[i]), 32'(exp_tr[i]));
    endtask

    // Start held high: three back-to-back conversions on instance 0.
    task automatic b2b(input logic [N-1:0] v);
        logic [N-1:0] exp_code;
        int t[$];
        int k = 0;
        exp_code = sar_ref(v);
        @(negedge clk);
        vin[0]   = v;
        start[0] = 1'b1;
        while (t.size() < 3 && k < 4 * LAT) begin
            @(negedge clk);
            k++;
            if (done[0]) begin
                t.push_back(k);
                chk("b2b_dout", 32'(dout[0]), 32'(exp_code));
                if (t.size() == 3) start[0] = 1'b0;
            end
        end
        start[0] = 1'b0;
        chk("b2b_count", t.size(), 3);
        if (t.size() > 0) chk("b2b_first", t[0], LAT);
        for (int i = 1; i < t.size(); i++) chk("b2b_gap", t[i] - t[i-1], LAT + 1);
        for (int j = 0; j < LAT + 3; j++) @(negedge clk);
        chk("b2b_idle", 32'(busy[0]), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("reset_busy", 32'(busy[s]), 32'd0);
            chk("reset_done", 32'(done[s]), 32'd0);
            chk("reset_sample", 32'(sample[s]), 32'd0);
            chk("reset_comp_en", 32'(comp_en[s]), 32'd0);
            chk("reset_dac", 32'(dac[s]), 32'd0);
            chk("reset_dout", 32'(dout[s]), 32'd0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        conv(0, 8'h3C, 0, 15, 8'h00);   // abort mid-conversion
        conv(0, 8'hA5, 0, 0, 8'h00);
        conv(0, 8'hFF, 0, 0, 8'h00);
        conv(0, 8'h00, 0, 0, 8'h00);
        conv(0, 8'h6E, 10, 0, 8'h00);   // Start re-pulsed mid-conversion
        conv(1, 8'h5A, 0, 0, 8'h00);    // inverted comparator polarity
        for (int r = 0; r < 8; r++)
            conv(int'($urandom_range(0, 1)), N'($urandom), 0, 0, 8'h00);
        b2b(8'hC3);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
